// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: thermometer stall generation, exception/eret
// flush sequencing with redirect target, and stall statistics with a watchdog.
module pipe_ctrl #(
   parameter int NSTAGE       = 6,
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 1,
   parameter int WDOG_LIMIT   = 255,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stall_req_i,
   input  logic              excp_valid_i,
   input  logic              excp_is_eret_i,
   input  logic [ADDR_W-1:0] epc_in_i,
   input  logic [ADDR_W-1:0] excp_base_i,
   input  logic              stat_clr_i,
   output logic [NSTAGE-1:0] stall_o,
   output logic              flush_o,
   output logic [ADDR_W-1:0] new_pc_o,
   output logic [CNT_W-1:0]  stall_cycles_o,
   output logic              stall_timeout_o
);

   localparam int              WDOG_W    = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
   localparam logic [3:0]      FCNT_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam bit              MULTI_CYC = (FLUSH_CYCLES > 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        fcnt_q, fcnt_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic [NSTAGE-1:0] therm;
   logic [ADDR_W-1:0] excp_tgt;

   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [WDOG_W-1:0] run_q, run_d;
   logic              to_q, to_d;
   logic              stalling;

   // A stage must hold whenever it or any younger-indexed stage above it stalls.
   always_comb begin
      therm = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         therm[i] = |(stall_req_i >> i);
      end
   end

   assign excp_tgt = excp_is_eret_i ? epc_in_i : excp_base_i;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      tgt_d    = tgt_q;
      stall_o  = '0;
      flush_o  = 1'b0;
      new_pc_o = '0;
      unique case (state_q)
         RUN: begin
            if (excp_valid_i) begin
               flush_o  = 1'b1;
               new_pc_o = excp_tgt;
               if (MULTI_CYC) begin
                  state_d = FLUSH;
                  fcnt_d  = FCNT_LOAD;
                  tgt_d   = excp_tgt;
               end
            end else begin
               stall_o = therm;
            end
         end
         FLUSH: begin
            flush_o  = 1'b1;
            new_pc_o = tgt_q;
            fcnt_d   = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      // Reset masks the outputs combinationally, even before the first edge.
      if (rst) begin
         stall_o  = '0;
         flush_o  = 1'b0;
         new_pc_o = '0;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         fcnt_q  <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         tgt_q   <= tgt_d;
      end
   end

   assign stalling = |stall_o;

   always_comb begin
      cyc_d = cyc_q;
      run_d = run_q;
      to_d  = to_q;
      if (stat_clr_i) begin
         cyc_d = '0;
         run_d = '0;
         to_d  = 1'b0;
      end else if (stalling) begin
         if (~&cyc_q) begin
            cyc_d = cyc_q + CNT_W'(1);
         end
         if (run_q < WDOG_MAX) begin
            run_d = run_q + WDOG_W'(1);
         end
         if (run_d == WDOG_MAX) begin
            to_d = 1'b1;
         end
      end else begin
         run_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
         run_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         run_q <= run_d;
         to_q  <= to_d;
      end
   end

   assign stall_cycles_o  = cyc_q;
   assign stall_timeout_o = to_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench: three pipe_ctrl configurations share one stimulus stream
// and are compared every cycle against a cycle-level behavioural model.
module tb_pipe_ctrl;

   localparam int NS  = 6;
   localparam int AW  = 32;
   localparam int NDUT = 3;

   logic          clk;
   logic          rst;
   logic [NS-1:0] stall_req;
   logic          excp_valid;
   logic          excp_is_eret;
   logic [AW-1:0] epc_in;
   logic [AW-1:0] excp_base;
   logic          stat_clr;

   logic [NS-1:0] dut_stall [NDUT];
   logic          dut_flush [NDUT];
   logic [AW-1:0] dut_pc    [NDUT];
   logic          dut_to    [NDUT];
   logic [63:0]   dut_cnt   [NDUT];
   logic [3:0]    cnt_a;
   logic [7:0]    cnt_b;
   logic [31:0]   cnt_c;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;

   // Per-instance model state: remaining FLUSH-state cycles, latched target,
   // saturating stall count, consecutive-stall run length, sticky timeout.
   int          m_fleft [NDUT];
   logic [31:0] m_tgt   [NDUT];
   longint      m_cnt   [NDUT];
   int          m_run   [NDUT];
   bit          m_to    [NDUT];

   pipe_ctrl #(.NSTAGE(NS), .ADDR_W(AW), .FLUSH_CYCLES(3), .WDOG_LIMIT(4), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst(rst), .stall_req_i(stall_req), .excp_valid_i(excp_valid),
      .excp_is_eret_i(excp_is_eret), .epc_in_i(epc_in), .excp_base_i(excp_base),
      .stat_clr_i(stat_clr), .stall_o(dut_stall[0]), .flush_o(dut_flush[0]),
      .new_pc_o(dut_pc[0]), .stall_cycles_o(cnt_a), .stall_timeout_o(dut_to[0]));

   pipe_ctrl #(.NSTAGE(NS), .ADDR_W(AW), .FLUSH_CYCLES(1), .WDOG_LIMIT(8), .CNT_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .stall_req_i(stall_req), .excp_valid_i(excp_valid),
      .excp_is_eret_i(excp_is_eret), .epc_in_i(epc_in), .excp_base_i(excp_base),
      .stat_clr_i(stat_clr), .stall_o(dut_stall[1]), .flush_o(dut_flush[1]),
      .new_pc_o(dut_pc[1]), .stall_cycles_o(cnt_b), .stall_timeout_o(dut_to[1]));

   pipe_ctrl #(.NSTAGE(NS), .ADDR_W(AW), .FLUSH_CYCLES(4), .WDOG_LIMIT(255), .CNT_W(32)) u_dut_c (
      .clk(clk), .rst(rst), .stall_req_i(stall_req), .excp_valid_i(excp_valid),
      .excp_is_eret_i(excp_is_eret), .epc_in_i(epc_in), .excp_base_i(excp_base),
      .stat_clr_i(stat_clr), .stall_o(dut_stall[2]), .flush_o(dut_flush[2]),
      .new_pc_o(dut_pc[2]), .stall_cycles_o(cnt_c), .stall_timeout_o(dut_to[2]));

   assign dut_cnt[0] = 64'(cnt_a);
   assign dut_cnt[1] = 64'(cnt_b);
   assign dut_cnt[2] = 64'(cnt_c);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   function automatic int cfg_fc(int d);
      case (d)
         0: return 3;
         1: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int cfg_wl(int d);
      case (d)
         0: return 4;
         1: return 8;
         default: return 255;
      endcase
   endfunction

   function automatic longint cfg_cmax(int d);
      case (d)
         0: return 64'd15;
         1: return 64'd255;
         default: return 64'hFFFF_FFFF;
      endcase
   endfunction

   // Highest requesting stage k -> low k+1 bits set.
   function automatic logic [NS-1:0] model_stall(logic [NS-1:0] req);
      int k;
      k = -1;
      for (int i = 0; i < NS; i++) begin
         if (req[i]) k = i;
      end
      if (k < 0) return '0;
      return NS'((64'd1 << (k + 1)) - 64'd1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at the negedge: compare every instance with the model, then advance the model.
   task automatic model_step();
      for (int d = 0; d < NDUT; d++) begin
         logic [NS-1:0] es;
         logic          ef;
         logic [31:0]   ep;
         es = '0;
         ef = 1'b0;
         ep = '0;
         if (rst) begin
            es = '0;
         end else if (m_fleft[d] > 0) begin
            ef = 1'b1;
            ep = m_tgt[d];
         end else if (excp_valid) begin
            ef = 1'b1;
            ep = excp_is_eret ? epc_in : excp_base;
         end else begin
            es = model_stall(stall_req);
         end
         if (model_on) begin
            check($sformatf("dut%0d stall", d), 64'(dut_stall[d]), 64'(es));
            check($sformatf("dut%0d flush", d), 64'(dut_flush[d]), 64'(ef));
            check($sformatf("dut%0d new_pc", d), 64'(dut_pc[d]), 64'(ep));
            check($sformatf("dut%0d stall_cycles", d), dut_cnt[d], 64'(m_cnt[d]));
            check($sformatf("dut%0d stall_timeout", d), 64'(dut_to[d]), 64'(m_to[d]));
         end
         if (rst) begin
            m_fleft[d] = 0;
            m_tgt[d]   = '0;
            m_cnt[d]   = 0;
            m_run[d]   = 0;
            m_to[d]    = 1'b0;
         end else begin
            if (m_fleft[d] > 0) begin
               m_fleft[d]--;
            end else if (excp_valid) begin
               m_fleft[d] = cfg_fc(d) - 1;
               m_tgt[d]   = ep;
            end
            if (stat_clr) begin
               m_cnt[d] = 0;
               m_run[d] = 0;
               m_to[d]  = 1'b0;
            end else if (es != '0) begin
               if (m_cnt[d] < cfg_cmax(d)) m_cnt[d]++;
               if (m_run[d] < cfg_wl(d)) m_run[d]++;
               if (m_run[d] == cfg_wl(d)) m_to[d] = 1'b1;
            end else begin
               m_run[d] = 0;
            end
         end
      end
   endtask

   task automatic apply(input bit r, input logic [NS-1:0] req, input bit ev, input bit er,
                        input logic [31:0] epc, input logic [31:0] base, input bit clr);
      @(posedge clk);
      #1;
      rst          = r;
      stall_req    = req;
      excp_valid   = ev;
      excp_is_eret = er;
      epc_in       = epc;
      excp_base    = base;
      stat_clr     = clr;
      @(negedge clk);
      model_step();
   endtask

   task automatic idle();
      apply(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      apply(1'b1, 6'h3f, 1'b1, 1'b0, 32'hdead_beef, 32'hcafe_f00d, 1'b0);
   endtask

   typedef struct {
      logic [NS-1:0] req;
      logic [NS-1:0] exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{req: 6'b001100, exp: 6'b001111};
      tbl[1] = '{req: 6'b000000, exp: 6'b000000};
      tbl[2] = '{req: 6'b000001, exp: 6'b000001};
      tbl[3] = '{req: 6'b001000, exp: 6'b001111};
      tbl[4] = '{req: 6'b000100, exp: 6'b000111};
      tbl[5] = '{req: 6'b100000, exp: 6'b111111};
      tbl[6] = '{req: 6'b010101, exp: 6'b011111};
      tbl[7] = '{req: 6'b000010, exp: 6'b000011};

      for (int d = 0; d < NDUT; d++) begin
         m_fleft[d] = 0;
         m_tgt[d]   = '0;
         m_cnt[d]   = 0;
         m_run[d]   = 0;
         m_to[d]    = 1'b0;
      end
      rst = 1'b1; stall_req = '0; excp_valid = 1'b0; excp_is_eret = 1'b0;
      epc_in = '0; excp_base = '0; stat_clr = 1'b0;

      // Outputs are masked while rst is high, even before any register is reset.
      do_reset();
      check("rst stall masked", 64'(dut_stall[0]), 64'd0);
      check("rst flush masked", 64'(dut_flush[0]), 64'd0);
      check("rst new_pc masked", 64'(dut_pc[0]), 64'd0);
      model_on = 1'b1;
      do_reset();
      idle();
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset cnt dut%0d", d), dut_cnt[d], 64'd0);
         check($sformatf("reset timeout dut%0d", d), 64'(dut_to[d]), 64'd0);
         check($sformatf("reset flush dut%0d", d), 64'(dut_flush[d]), 64'd0);
      end

      // Thermometer stall table.
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, tbl[i].req, 1'b0, 1'b0, '0, '0, 1'b0);
         check($sformatf("therm vec%0d", i), 64'(dut_stall[0]), 64'(tbl[i].exp));
      end

      // Three-cycle flush; a second exception mid-flush neither restarts nor retargets it.
      do_reset();
      idle();
      apply(1'b0, 6'h3f, 1'b1, 1'b0, '0, 32'h40, 1'b0);
      check("flush3 c1 flush", 64'(dut_flush[0]), 64'd1);
      check("flush3 c1 stall", 64'(dut_stall[0]), 64'd0);
      check("flush3 c1 pc", 64'(dut_pc[0]), 64'h40);
      apply(1'b0, 6'h3f, 1'b1, 1'b0, '0, 32'h80, 1'b0);
      check("flush3 c2 flush", 64'(dut_flush[0]), 64'd1);
      check("flush3 c2 pc", 64'(dut_pc[0]), 64'h40);
      apply(1'b0, 6'h3f, 1'b0, 1'b0, '0, 32'h80, 1'b0);
      check("flush3 c3 flush", 64'(dut_flush[0]), 64'd1);
      check("flush3 c3 stall", 64'(dut_stall[0]), 64'd0);
      idle();
      check("flush3 end flush", 64'(dut_flush[0]), 64'd0);
      check("flush3 end pc", 64'(dut_pc[0]), 64'd0);

      // Single-cycle eret.
      do_reset();
      idle();
      apply(1'b0, 6'h01, 1'b1, 1'b1, 32'h1234, 32'h40, 1'b0);
      check("eret1 flush", 64'(dut_flush[1]), 64'd1);
      check("eret1 pc", 64'(dut_pc[1]), 64'h1234);
      idle();
      check("eret1 next flush", 64'(dut_flush[1]), 64'd0);
      check("eret1 next pc", 64'(dut_pc[1]), 64'd0);

      // Watchdog at 4 consecutive stalls, sticky until stat_clr.
      do_reset();
      idle();
      for (int i = 0; i < 4; i++) apply(1'b0, 6'b000010, 1'b0, 1'b0, '0, '0, 1'b0);
      check("wdog before 4th edge", 64'(dut_to[0]), 64'd0);
      idle();
      check("wdog after 4th edge", 64'(dut_to[0]), 64'd1);
      check("wdog stall_cycles", dut_cnt[0], 64'd4);
      idle();
      check("wdog sticky", 64'(dut_to[0]), 64'd1);
      apply(1'b0, 6'b000010, 1'b0, 1'b0, '0, '0, 1'b1);
      idle();
      check("stat_clr timeout", 64'(dut_to[0]), 64'd0);
      check("stat_clr cycles", dut_cnt[0], 64'd0);

      // 4-bit statistics counter saturates.
      do_reset();
      idle();
      for (int i = 0; i < 20; i++) apply(1'b0, 6'b000100, 1'b0, 1'b0, '0, '0, 1'b0);
      apply(1'b0, 6'b000100, 1'b0, 1'b0, '0, '0, 1'b0);
      check("cnt sat 15", dut_cnt[0], 64'd15);
      idle();
      check("cnt sat hold", dut_cnt[0], 64'd15);

      // Reset in the second cycle of a four-cycle flush aborts it.
      do_reset();
      idle();
      apply(1'b0, '0, 1'b1, 1'b0, '0, 32'h40, 1'b0);
      check("abort c1 flush", 64'(dut_flush[2]), 64'd1);
      apply(1'b1, 6'h3f, 1'b1, 1'b0, '0, 32'h40, 1'b0);
      check("abort rst flush", 64'(dut_flush[2]), 64'd0);
      check("abort rst pc", 64'(dut_pc[2]), 64'd0);
      apply(1'b0, 6'b000001, 1'b0, 1'b0, '0, 32'h40, 1'b0);
      check("abort after flush", 64'(dut_flush[2]), 64'd0);
      check("abort after pc", 64'(dut_pc[2]), 64'd0);
      check("abort after stall", 64'(dut_stall[2]), 64'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         logic [NS-1:0] req;
         req = ($urandom_range(0, 3) == 0) ? '0 : NS'($urandom);
         apply($urandom_range(0, 99) == 0, req, $urandom_range(0, 7) == 0,
               1'($urandom), $urandom, $urandom, $urandom_range(0, 31) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, default 6, SHALL set the number of pipeline stages; bit 0 is the PC stage and bit NSTAGE-1 is write-back.
REQ-002 Parameter ADDR_W, default 32, SHALL set the width of the PC and vector fields.
REQ-003 Parameter FLUSH_CYCLES, default 1, range 1..15, SHALL set the flush pulse length in cycles.
REQ-004 Parameter WDOG_LIMIT, default 255, SHALL set the consecutive-stall count that raises the timeout.
REQ-005 Parameter CNT_W, default 32, SHALL set the stall statistics counter width.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stall_req  in  NSTAGE  stall request; bit i comes from stage i.
REQ-009 excp_valid  in  1  exception or eret reported by the commit stage.
REQ-010 excp_is_eret  in  1  qualifies excp_valid as a return from exception.
REQ-011 epc_in  in  ADDR_W  return address used for eret.
REQ-012 excp_base  in  ADDR_W  handler entry address used for exceptions.
REQ-013 stat_clr  in  1  clears stall_cycles and stall_timeout.
REQ-014 stall  out  NSTAGE  per-stage hold; bit i set freezes stage i.
REQ-015 flush  out  1  pipeline flush.
REQ-016 new_pc  out  ADDR_W  redirect target; valid only while flush=1.
REQ-017 stall_cycles  out  CNT_W  count of cycles with stall != 0.
REQ-018 stall_timeout  out  1  sticky watchdog flag.

Function
REQ-019 The block SHALL contain a two-state FSM, RUN and FLUSH, and a 4-bit flush counter fcnt.
REQ-020 In RUN, with k the highest index where stall_req[k]=1, stall SHALL equal bits 0..k set and all other bits clear; stall SHALL be 0 if stall_req=0.
REQ-021 In RUN, stall SHALL be combinational from stall_req, with zero-cycle latency.
REQ-022 For NSTAGE=6, stall_req=6'b001000 SHALL give stall=6'b001111, and stall_req=6'b000100 SHALL give stall=6'b000111.
REQ-023 When excp_valid=1 in RUN, flush SHALL assert combinationally in the same cycle.
REQ-024 In that same cycle, stall SHALL be forced to 0, since flush overrides stall.
REQ-025 In that same cycle, new_pc SHALL equal epc_in if excp_is_eret=1, and excp_base otherwise.
REQ-026 At the clock edge of that cycle, the FSM SHALL enter FLUSH if FLUSH_CYCLES>1 and latch the selected target; with FLUSH_CYCLES=1 it SHALL stay in RUN.
REQ-027 On entry to FLUSH, fcnt SHALL load FLUSH_CYCLES-1.
REQ-028 In FLUSH, flush SHALL be 1, stall SHALL be 0, new_pc SHALL hold the latched target, and fcnt SHALL decrement each cycle.
REQ-029 When fcnt reaches 1, the FSM SHALL return to RUN on the next edge, so flush is high for exactly FLUSH_CYCLES cycles in total.
REQ-030 In FLUSH, excp_valid and stall_req SHALL be ignored; a new exception SHALL NOT restart or extend the flush.
REQ-031 When flush=0, new_pc SHALL drive 0.
REQ-032 stall_cycles SHALL increment by 1 on every edge where stall!=0, and SHALL saturate at all-ones without wrapping.
REQ-033 A consecutive-stall counter SHALL increment while stall!=0 and clear on any cycle where stall=0; it SHALL saturate at WDOG_LIMIT.
REQ-034 When the consecutive-stall counter reaches WDOG_LIMIT, stall_timeout SHALL set on that edge and stay set until rst or stat_clr.
REQ-035 stat_clr SHALL clear stall_cycles, stall_timeout and the consecutive counter on the next edge, and SHALL take priority over the same-cycle increment.
REQ-036 stat_clr SHALL NOT affect the FSM.

Reset
REQ-037 On a clock edge with rst=1, the FSM SHALL go to RUN, and fcnt, the latched target, stall_cycles, the consecutive counter and stall_timeout SHALL clear to 0.
REQ-038 While rst=1, stall SHALL be 0, flush SHALL be 0 and new_pc SHALL be 0, regardless of all other inputs.
REQ-039 Reset asserted during FLUSH SHALL abort the flush at that edge.
REQ-040 After rst is released, the block SHALL respond to inputs in the first following cycle.

Verification
REQ-041 NSTAGE=6, stall_req=6'b001100 -> stall=6'b001111; stall_req=0 -> stall=0; stall_req=6'b000001 -> stall=6'b000001.
REQ-042 FLUSH_CYCLES=3, excp_valid=1, excp_is_eret=0, excp_base=0x00000040, stall_req=6'b111111 -> flush=1, stall=0, new_pc=0x40 for exactly 3 cycles; a second excp_valid in cycle 2 -> no extension.
REQ-043 FLUSH_CYCLES=1, excp_is_eret=1, epc_in=0x00001234 -> flush=1 and new_pc=0x1234 for one cycle; the next cycle gives flush=0 and new_pc=0.
REQ-044 WDOG_LIMIT=4, stall_req held nonzero for 4 cycles -> stall_timeout=1 after the 4th edge and stays 1 after stall_req=0; stat_clr=1 -> timeout=0 and stall_cycles=0.
REQ-045 CNT_W=4, stall held for 20 cycles -> stall_cycles=15 and holds at 15.
REQ-046 FLUSH_CYCLES=4, rst=1 asserted in the 2nd flush cycle -> flush=0, new_pc=0 and FSM in RUN after that edge.
